md_sequencer: RTL

//   Cycle-accurate sequencer and HI/LO owner for the EX-stage multiply/divide unit.

---
 rtl/md_sequencer.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/md_sequencer.sv
// md_sequencer: sequencer and HI/LO owner for the EX-stage multiply/divide unit.
//
// EX issues a one-cycle start pulse with md_op and forwarded operands A/B.
// mult/multu/div/divu compute their result into shadow registers on the issue
// edge. The unit then stays busy for a fixed MULT_CYCLES/DIV_CYCLES countdown
// and commits the shadow values to HI/LO on the final edge. mthi/mtlo write
// HI/LO directly on the issue edge and never raise busy. The ID-stage stall is
// the only combinational output. It also covers the issue cycle itself, so an
// instruction that depends on HI/LO cannot slip past an op that is just being
// issued.

module md_sequencer #(
    parameter int MULT_CYCLES = 5,  // busy cycles for mult/multu (>= 1)
    parameter int DIV_CYCLES  = 10  // busy cycles for div/divu   (>= 1)
) (
    input  logic        clk,
    input  logic        reset,      // asynchronous, active-low
    input  logic        start,      // EX issue pulse for md_op
    input  logic [2:0]  md_op,
    input  logic [31:0] A,          // rs operand
    input  logic [31:0] B,          // rt operand
    input  logic        id_md_use,  // ID-stage instruction touches the MD unit
    output logic        busy,
    output logic        stall,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    // Operation encoding of md_op.
    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6,
        OP_RSVD  = 3'd7
    } md_op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    // The countdown must hold the longer of the two latencies.
    localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_MULT = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_DIV  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [31:0] INT_MIN = 32'h8000_0000;
    localparam logic [31:0] NEG_ONE = 32'hFFFF_FFFF;

    md_op_e op;

    // Registered state and outputs.
    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      shadow_hi_q;
    logic [31:0]      shadow_lo_q;
    logic             commit_q;     // clear when a divide by zero must not touch HI/LO
    logic             busy_q;
    logic             done_q;
    logic [31:0]      hi_q;
    logic [31:0]      lo_q;

    // Result of the operation presented this cycle. It is captured into the
    // shadow registers on the issue edge.
    logic [31:0]      shadow_hi_d;
    logic [31:0]      shadow_lo_d;
    logic             commit_d;
    logic [63:0]      prod;
    logic             is_md_issue;

    assign op          = md_op_e'(md_op);
    assign is_md_issue = start && (op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU});

    // Result datapath: product, or quotient and remainder, of the current operands.
    always_comb begin
        // NOTE: every variable gets a default first, so no path through the case leaves one unassigned and infers a latch.
        shadow_hi_d = 32'h0;
        shadow_lo_d = 32'h0;
        commit_d    = 1'b1;
        prod        = 64'h0;
        unique case (op)
            OP_MULT: begin
                // The low 64 bits of the sign-extended operands' product equal the signed product.
                prod        = {{32{A[31]}}, A} * {{32{B[31]}}, B};
                shadow_hi_d = prod[63:32];
                shadow_lo_d = prod[31:0];
            end
            OP_MULTU: begin
                prod        = {32'h0, A} * {32'h0, B};
                shadow_hi_d = prod[63:32];
                shadow_lo_d = prod[31:0];
            end
            OP_DIV: begin
                if (B == 32'h0) begin
                    commit_d = 1'b0;
                end else if (A == INT_MIN && B == NEG_ONE) begin
                    // The quotient overflows. Define it as the dividend with a zero remainder.
                    shadow_lo_d = INT_MIN;
                    shadow_hi_d = 32'h0;
                end else begin
                    // Signed / and % truncate toward zero. The remainder takes the dividend's sign.
                    shadow_lo_d = $signed(A) / $signed(B);
                    shadow_hi_d = $signed(A) % $signed(B);
                end
            end
            OP_DIVU: begin
                if (B == 32'h0) begin
                    commit_d = 1'b0;
                end else begin
                    shadow_lo_d = A / B;
                    shadow_hi_d = A % B;
                end
            end
            default: begin
                // mthi/mtlo/none/reserved: the result path is unused.
            end
        endcase
    end

    // Sequencer FSM: issue, countdown, commit. It also owns HI/LO.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            shadow_hi_q <= 32'h0;
            shadow_lo_q <= 32'h0;
            commit_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            hi_q        <= 32'h0;
            lo_q        <= 32'h0;
        end else begin
            // NOTE: state uses non-blocking assignments, so every branch reads values from before the edge.
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        unique case (op)
                            OP_MULT, OP_MULTU: begin
                                state_q     <= S_RUN;
                                cnt_q       <= CNT_MULT;
                                busy_q      <= 1'b1;
                                shadow_hi_q <= shadow_hi_d;
                                shadow_lo_q <= shadow_lo_d;
                                commit_q    <= commit_d;
                            end
                            OP_DIV, OP_DIVU: begin
                                state_q     <= S_RUN;
                                cnt_q       <= CNT_DIV;
                                busy_q      <= 1'b1;
                                shadow_hi_q <= shadow_hi_d;
                                shadow_lo_q <= shadow_lo_d;
                                commit_q    <= commit_d;
                            end
                            OP_MTHI: hi_q <= A;
                            OP_MTLO: lo_q <= A;
                            default: begin
                                // none/reserved: ignored
                            end
                        endcase
                    end
                end
                S_RUN: begin
                    // The hazard protocol keeps start low here, so any start in RUN is dropped.
                    if (cnt_q == CNT_ONE) begin
                        if (commit_q) begin
                            hi_q <= shadow_hi_q;
                            lo_q <= shadow_lo_q;
                        end
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Hold ID while an MD op is in flight or being issued right now.
    assign stall = id_md_use & (busy_q | is_md_issue);

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
